// File: rtl/audio_rate_gen.sv
// audio_rate_gen
//
// Fractional-phase audio sample-strobe generator. Each enabled cycle the phase
// accumulator adds the selected sample rate. When the sum reaches CLKRATE,
// one strobe is produced and CLKRATE is subtracted. The long-term strobe rate
// therefore equals RATEn exactly, with no prescaler rounding error. Strobes
// are numbered 0..191 within the IEC 60958 channel-status block. block_start
// marks frame 0 so the packetiser can place the B preamble.
//
// Parameters:
//   CLKRATE     system clock frequency in Hz
//   RATE0..3    sample rates selected by rate_sel (each <= CLKRATE/2)
//   ACC_W       accumulator width; 2^ACC_W must exceed CLKRATE + max(RATEn)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   1 = accumulate, 0 = freeze state and suppress pulses
//   rate_sel[1:0] in   sample-rate select
//   audio_stb     out  one-cycle sample strobe
//   block_start   out  high with audio_stb on frame 0 of a block
//   frame_idx[7:0]out  frame number of the current strobe; held between strobes
//   rate_changed  out  one-cycle pulse on the edge a new rate_sel takes effect

module audio_rate_gen #(
  parameter int CLKRATE = 28000000,
  parameter int RATE0   = 32000,
  parameter int RATE1   = 44100,
  parameter int RATE2   = 48000,
  parameter int RATE3   = 192000,
  parameter int ACC_W   = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] rate_sel,
  output logic       audio_stb,
  output logic       block_start,
  output logic [7:0] frame_idx,
  output logic       rate_changed
);

  localparam logic [ACC_W-1:0] CLK_A      = ACC_W'(CLKRATE);
  localparam logic [7:0]       LAST_FRAME = 8'd191;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [1:0]       sel_q;
  logic [1:0]       sel_nxt;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic [7:0]       frame_idx_nxt;
  logic             stb_nxt;
  logic             bs_nxt;
  logic             rc_nxt;

  logic [ACC_W-1:0] rate_r;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_wrap;
  logic             hit;

  always_comb begin
    case (sel_q)
      2'd0:    rate_r = ACC_W'(RATE0);
      2'd1:    rate_r = ACC_W'(RATE1);
      2'd2:    rate_r = ACC_W'(RATE2);
      default: rate_r = ACC_W'(RATE3);
    endcase
  end

  // sum is one bit wider than the accumulator, so acc + R cannot overflow.
  // After a hit, the difference is below CLKRATE and fits in ACC_W bits, so
  // the subtraction can be done modulo 2^ACC_W on the low bits.
  assign sum      = {1'b0, acc} + {1'b0, rate_r};
  assign hit      = (sum >= {1'b0, CLK_A});
  assign acc_wrap = sum[ACC_W-1:0] - CLK_A;

  always_comb begin
    acc_nxt       = acc;
    sel_nxt       = sel_q;
    cnt_nxt       = cnt;
    frame_idx_nxt = frame_idx;
    stb_nxt       = 1'b0;
    bs_nxt        = 1'b0;
    rc_nxt        = 1'b0;

    if (enable) begin
      if (rate_sel != sel_q) begin
        // A rate change restarts phase and block numbering from zero.
        // Accumulation at the new rate begins on the following edge.
        sel_nxt       = rate_sel;
        acc_nxt       = '0;
        cnt_nxt       = '0;
        frame_idx_nxt = '0;
        rc_nxt        = 1'b1;
      end else if (hit) begin
        acc_nxt       = acc_wrap;
        stb_nxt       = 1'b1;
        frame_idx_nxt = cnt;
        bs_nxt        = (cnt == 8'd0);
        cnt_nxt       = (cnt == LAST_FRAME) ? 8'd0 : cnt + 8'd1;
      end else begin
        acc_nxt = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      sel_q        <= '0;
      cnt          <= '0;
      frame_idx    <= '0;
      audio_stb    <= 1'b0;
      block_start  <= 1'b0;
      rate_changed <= 1'b0;
    end else begin
      acc          <= acc_nxt;
      sel_q        <= sel_nxt;
      cnt          <= cnt_nxt;
      frame_idx    <= frame_idx_nxt;
      audio_stb    <= stb_nxt;
      block_start  <= bs_nxt;
      rate_changed <= rc_nxt;
    end
  end

endmodule
